seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Scans an 8-digit, common-anode 7-segment display from one 32-bit hex word, one digit per time slot.
//  Holds its own scan prescaler and 3-bit digit index; decodes hex nibbles to segment patterns.
//  Frame-synchronous load handshake: new contents commit only at a frame boundary, so no tearing.
//  Sits between the CPU/IO register block (data source) and the board anode/segment pins.
// PARAMETERS
//  SCAN_DIV       100000  clk cycles per digit slot (>=2); 1 kHz slot rate at 100 MHz
//  BLANK_CYC      16      cycles at slot start with all anodes off (ghost suppression); 0 = off; < SCAN_DIV
//  SEG_ACTIVE_LOW 1       1: seg/seg_dp driven active-low; 0: active-high
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   synchronous reset, active-low
//  data       in   32  nibble i (data[4i+3:4i]) -> digit i
//  dp         in   8   decimal point per digit, 1 = lit
//  digit_en   in   8   per-digit enable, 0 = digit dark
//  load       in   1   level request: capture data/dp/digit_en for display
//  load_ack   out  1   one-cycle pulse: captured contents committed to display
//  frame_tick out  1   one-cycle pulse: digit index wrapped 7->0
//  an         out  8   anode select, one-hot active-low
//  seg        out  7   segments {g,f,e,d,c,b,a}
//  seg_dp     out  1   decimal-point segment
// BEHAVIOUR
//  Reset (rst==0 at posedge): cnt=0, idx=0, pending=0; shadow and display regs=0, incl. display digit_en=0.
//   an=8'hFF; seg/seg_dp off (7'h7F/1 if SEG_ACTIVE_LOW); load_ack=0; frame_tick=0.
//   Reset mid-operation discards any pending load; no ack is issued.
//  Prescaler: cnt counts 0..SCAN_DIV-1 then wraps; tick = (cnt==SCAN_DIV-1).
//  On tick: idx <= idx+1 (3-bit, 7 wraps to 0); frame_tick=1 in the cycle idx becomes 0.
//  Load path:
//   load==1 in any cycle: shadow <= {data,dp,digit_en}; pending <= 1. Latest load wins.
//   Commit cycle = tick && idx==7. If pending or load: display <= (load ? inputs : shadow); pending <= 0.
//   load_ack=1 for exactly one cycle, the cycle after commit. One ack per commit, however many loads merged.
//   load held high continuously: commit every frame, ack every frame.
//  Output stage (registered; outputs at cycle t+1 reflect cnt/idx/display at cycle t):
//   cnt < BLANK_CYC or display digit_en[idx]==0 -> an=8'hFF.
//   Otherwise an=~(8'b1<<idx).
//   seg = decode(display nibble idx); seg_dp = display dp[idx]; inverted if SEG_ACTIVE_LOW.
//   Disabled digit: seg/seg_dp driven off.
//  Decode, active-high {g..a}:
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//   8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//  First frame after reset is dark: display digit_en=0 until the first commit.
//  No combinational input->output paths.
// TESTING (SCAN_DIV=4, BLANK_CYC=1, SEG_ACTIVE_LOW=1; slot=4 cyc, frame=32 cyc)
//  1 Reset, hold load=0 for 64 cyc -> an==8'hFF, seg==7'h7F, seg_dp==1, load_ack never 1; frame_tick every 32 cyc.
//  2 load=1 one cyc, data=32'h76543210, dp=8'h01, en=8'hFF -> ack 1 cyc after next idx7->0 tick.
//    Following digit-0 slot: an=8'hFE, seg=7'h40, seg_dp=0. Digit-7 slot: an=8'h7F, seg=7'h78.
//  3 Blanking, after case 2 -> every slot: 1 cyc an=8'hFF, then 3 cyc one-hot. Never two anodes low at once.
//  4 load 32'h11111111, then 32'h22222222 before the commit -> single ack; all digits show seg=7'h24; 1 never shown.
//  5 en=8'h0F committed -> an[7:4] stay 1 for 5 frames; slots 4-7: seg=7'h7F, seg_dp=1.
//  6 load then rst=0 mid-frame, before commit -> no ack after reset release; an==8'hFF for the next 2 frames.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans an 8-digit common-anode 7-segment display from a frame-synchronously loaded hex word
module seg_scan_driver #(
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_tick,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        seg_dp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK = CW'(BLANK_CYC);
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          pending;
    logic [31:0]   sh_data, dsp_data;
    logic [7:0]    sh_dp, sh_en, dsp_dp, dsp_en;
    logic          tick, commit, on, lit, dp_on;
    logic [3:0]    nib;
    logic [6:0]    dec, seg_on;
    always_comb begin
        tick   = cnt == LAST;
        commit = tick && idx == 3'd7 && (pending || load);
        on     = dsp_en[idx];
        lit    = on && cnt >= BLK;
        nib    = dsp_data[{idx, 2'b00} +: 4];
        dec    = 7'h00;
        case (nib)
            4'h0: dec = 7'h3F;
            4'h1: dec = 7'h06;
            4'h2: dec = 7'h5B;
            4'h3: dec = 7'h4F;
            4'h4: dec = 7'h66;
            4'h5: dec = 7'h6D;
            4'h6: dec = 7'h7D;
            4'h7: dec = 7'h07;
            4'h8: dec = 7'h7F;
            4'h9: dec = 7'h6F;
            4'hA: dec = 7'h77;
            4'hB: dec = 7'h7C;
            4'hC: dec = 7'h39;
            4'hD: dec = 7'h5E;
            4'hE: dec = 7'h79;
            default: dec = 7'h71;
        endcase
        seg_on = on ? dec : 7'h00;
        dp_on  = on && dsp_dp[idx];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            dsp_data   <= '0;
            dsp_dp     <= '0;
            dsp_en     <= '0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 8'hFF;
            seg        <= {7{SEG_ACTIVE_LOW}};
            seg_dp     <= SEG_ACTIVE_LOW;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            idx <= tick ? idx + 1'b1 : idx;
            if (load)
                {sh_data, sh_dp, sh_en} <= {data, dp, digit_en};
            pending <= commit ? 1'b0 : (pending || load);
            // a load arriving in the commit cycle itself goes straight to the display
            if (commit)
                {dsp_data, dsp_dp, dsp_en} <= load ? {data, dp, digit_en} : {sh_data, sh_dp, sh_en};
            load_ack   <= commit;
            frame_tick <= tick && idx == 3'd7;
            an         <= lit ? ~(8'b1 << idx) : 8'hFF;
            seg        <= seg_on ^ {7{SEG_ACTIVE_LOW}};
            seg_dp     <= dp_on ^ SEG_ACTIVE_LOW;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed stimulus with an ack scoreboard and continuous frame/anode monitors
module tb_seg_scan_driver;
    logic        clk = 1'b0, rst = 1'b0, load = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dp = '0, digit_en = '0;
    logic        load_ack, frame_tick, seg_dp;
    logic [7:0]  an, oh;
    logic [6:0]  seg;
    int          n = 0, checks = 0, failures = 0, k, j;
    bit          run = 1'b0;
    int          ack_q[$];
    logic [6:0]  seg3 [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [6:0]  seg5 [4] = '{7'h00, 7'h10, 7'h08, 7'h03};

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .digit_en(digit_en), .load(load),
        .load_ack(load_ack), .frame_tick(frame_tick), .an(an), .seg(seg), .seg_dp(seg_dp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) n <= rst ? n + 1 : 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at n=%0d", name, got, exp, n);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ean, input logic [6:0] eseg, input logic edp, input bit do_seg);
        chk({tag, "_an"}, an, ean);
        if (do_seg) begin
            chk({tag, "_seg"}, seg, eseg);
            chk({tag, "_dp"}, seg_dp, edp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic void push_ack(input int v);
        if (ack_q.size() == 0 || ack_q[$] != v) ack_q.push_back(v);
    endfunction

    always @(negedge clk) if (run) begin
        chk("frame_tick", frame_tick, n != 0 && n % 32 == 0);
        chk("an_onehot", $countones(~an) <= 1, 1);
        if (load_ack) begin
            if (ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ack_unexpected: got ack at n=%0d expected none", n);
            end else begin
                chk("ack_cycle", n, ack_q[0]);
                void'(ack_q.pop_front());
            end
        end
        if (ack_q.size() > 0 && n > ack_q[0]) begin
            checks++;
            failures++;
            $display("FAIL ack_missing: got no ack by n=%0d expected at n=%0d", n, ack_q[0]);
            void'(ack_q.pop_front());
        end
    end

    initial begin
        step;
        run = 1'b1;
        chk_out("rst", 8'hFF, 7'h7F, 1'b1, 1'b1);
        chk("rst_ack", load_ack, 0);
        step;
        step;
        rst = 1'b1;
        repeat (64) begin
            step;
            chk_out("idle", 8'hFF, 7'h7F, 1'b1, 1'b1);
        end
        data = 32'h76543210; dp = 8'h01; digit_en = 8'hFF; load = 1'b1;
        push_ack(96);
        step;
        load = 1'b0;
        while (n < 96) step;
        repeat (32) begin
            step;
            k = ((n - 1) % 32) / 4; j = (n - 1) % 4; oh = 8'b1 << k;
            if (j == 0) chk_out("c3_blank", 8'hFF, 7'h7F, 1'b1, 1'b0);
            else chk_out("c3_lit", ~oh, seg3[k], k != 0, 1'b1);
        end
        data = 32'h11111111; dp = 8'h00; digit_en = 8'hFF; load = 1'b1;
        push_ack(160);
        step;
        load = 1'b0;
        step;
        data = 32'h22222222; load = 1'b1;
        push_ack(160);
        step;
        load = 1'b0;
        while (n < 160) step;
        repeat (32) begin
            step;
            k = ((n - 1) % 32) / 4; j = (n - 1) % 4; oh = 8'b1 << k;
            if (j == 0) chk_out("c4_blank", 8'hFF, 7'h7F, 1'b1, 1'b0);
            else chk_out("c4_lit", ~oh, 7'h24, 1'b1, 1'b1);
        end
        data = 32'hFEDCBA98; dp = 8'hF0; digit_en = 8'h0F; load = 1'b1;
        push_ack(224);
        step;
        load = 1'b0;
        while (n < 224) step;
        repeat (160) begin
            step;
            k = ((n - 1) % 32) / 4; j = (n - 1) % 4; oh = 8'b1 << k;
            if (k >= 4) chk_out("c5_off", 8'hFF, 7'h7F, 1'b1, 1'b1);
            else if (j == 0) chk_out("c5_blank", 8'hFF, 7'h7F, 1'b1, 1'b0);
            else chk_out("c5_lit", ~oh, seg5[k], 1'b1, 1'b1);
        end
        data = 32'h33333333; dp = 8'hFF; digit_en = 8'hFF; load = 1'b1;
        push_ack(416);
        step;
        load = 1'b0;
        while (n < 400) step;
        rst = 1'b0;
        ack_q.delete();
        step;
        step;
        rst = 1'b1;
        repeat (64) begin
            step;
            chk("c6_dark_an", an, 8'hFF);
        end
        repeat (8) step;
        chk("ack_queue_empty", ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
